// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
package alu_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } opcode_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, carry/borrow and signed overflow.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [1:0]       opcode,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH:0] sum_full;
   logic [WIDTH:0] diff_full;

   // Operation select; the extra top bit of diff_full is the unsigned borrow.
   always_comb begin
      sum_full  = {1'b0, op1} + {1'b0, op2};
      diff_full = {1'b0, op1} - {1'b0, op2};
      result    = sum_full[WIDTH-1:0];
      carry     = 1'b0;
      overflow  = 1'b0;
      unique case (opcode_e'(opcode))
         OP_ADD: begin
            result   = sum_full[WIDTH-1:0];
            carry    = sum_full[WIDTH];
            overflow = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                       (sum_full[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_SUB: begin
            result   = diff_full[WIDTH-1:0];
            carry    = diff_full[WIDTH];
            overflow = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                       (diff_full[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_AND: result = op1 & op2;
         OP_OR:  result = op1 | op2;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, outputs hold while no valid input.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [1:0]       opcode,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   logic [WIDTH-1:0] core_result;
   logic             core_carry;
   logic             core_overflow;

   logic [WIDTH-1:0] y_q, y_d;
   logic             out_valid_q, out_valid_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             negative_q, negative_d;
   logic             overflow_q, overflow_d;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op1      (op1),
      .op2      (op2),
      .opcode   (opcode),
      .result   (core_result),
      .carry    (core_carry),
      .overflow (core_overflow)
   );

   // Load new result and flags on valid input, otherwise hold; flags come from
   // the result being registered rather than from the current y.
   always_comb begin
      y_d         = y_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      negative_d  = negative_q;
      overflow_d  = overflow_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         y_d        = core_result;
         carry_d    = core_carry;
         zero_d     = (core_result == '0);
         negative_d = core_result[WIDTH-1];
         overflow_d = core_overflow;
      end
   end

   // Output registers; synchronous reset wins over an operation in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= '0;
         out_valid_q <= 1'b0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b1;
         negative_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         negative_q  <= negative_d;
         overflow_q  <= overflow_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign negative  = negative_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, monitor pops on out_valid.
module tb_alu;
   import alu_pkg::*;

   localparam int unsigned W = 4;

   typedef struct packed {
      logic [W-1:0] y;
      logic         c;
      logic         z;
      logic         n;
      logic         o;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] op1 = '0;
   logic [W-1:0] op2 = '0;
   logic [1:0]   opcode = 2'b00;
   logic         in_valid = 1'b0;
   logic [W-1:0] y;
   logic         out_valid, carry, zero, negative, overflow;

   exp_t sb[$];
   logic exp_ov = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   alu #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .op1       (op1),
      .op2       (op2),
      .opcode    (opcode),
      .in_valid  (in_valid),
      .y         (y),
      .out_valid (out_valid),
      .carry     (carry),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
      op1 = a; op2 = b; opcode = opc; in_valid = 1'b1;
      if (!rst) sb.push_back(e);
      step();
   endtask

   task automatic chk_outputs(input string tag, input exp_t e, input logic ov);
      chk({tag, ".y"}, 32'(y), 32'(e.y));
      chk({tag, ".carry"}, 32'(carry), 32'(e.c));
      chk({tag, ".zero"}, 32'(zero), 32'(e.z));
      chk({tag, ".negative"}, 32'(negative), 32'(e.n));
      chk({tag, ".overflow"}, 32'(overflow), 32'(e.o));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
   endtask

   // Reference valid pipeline: an accepted operation shows one cycle later.
   always @(posedge clk) exp_ov <= in_valid && !rst;

   // Monitor: check valid timing, then pop and compare each presented result.
   always @(negedge clk) begin
      exp_t e;
      chk("mon.out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mon.unexpected: got result %h expected none at %0t", y, $time);
         end else begin
            e = sb.pop_front();
            chk("mon.y", 32'(y), 32'(e.y));
            chk("mon.carry", 32'(carry), 32'(e.c));
            chk("mon.zero", 32'(zero), 32'(e.z));
            chk("mon.negative", 32'(negative), 32'(e.n));
            chk("mon.overflow", 32'(overflow), 32'(e.o));
         end
      end
   end

   localparam exp_t RST_VAL = '{y: 4'h0, c: 1'b0, z: 1'b1, n: 1'b0, o: 1'b0};

   initial begin
      // Two reset cycles
      step();
      step();
      chk_outputs("reset", RST_VAL, 1'b0);
      rst = 1'b0;

      // Directed vectors: y, carry, zero, negative, overflow
      issue(OP_ADD, 4'h5, 4'h8, '{y: 4'hD, c: 0, z: 0, n: 1, o: 0});
      issue(OP_SUB, 4'hA, 4'h8, '{y: 4'h2, c: 0, z: 0, n: 0, o: 0});
      issue(OP_AND, 4'hA, 4'h8, '{y: 4'h8, c: 0, z: 0, n: 1, o: 0});
      issue(OP_OR,  4'hA, 4'h8, '{y: 4'hA, c: 0, z: 0, n: 1, o: 0});
      issue(OP_ADD, 4'hF, 4'h1, '{y: 4'h0, c: 1, z: 1, n: 0, o: 0});
      issue(OP_ADD, 4'h7, 4'h1, '{y: 4'h8, c: 0, z: 0, n: 1, o: 1});
      issue(OP_AND, 4'h5, 4'hA, '{y: 4'h0, c: 0, z: 1, n: 0, o: 0});
      issue(OP_SUB, 4'h3, 4'h5, '{y: 4'hE, c: 1, z: 0, n: 1, o: 0});
      issue(OP_SUB, 4'h8, 4'h1, '{y: 4'h7, c: 0, z: 0, n: 0, o: 1});

      // Hold: operands change with in_valid low, last result must stay
      in_valid = 1'b0;
      op1 = 4'h1; op2 = 4'h1; opcode = OP_ADD;
      step();
      op1 = 4'hF; op2 = 4'h3; opcode = OP_OR;
      step();
      chk_outputs("hold", '{y: 4'h7, c: 0, z: 0, n: 0, o: 1}, 1'b0);

      // Reset wins over a valid operation in the same cycle
      rst = 1'b1;
      issue(OP_ADD, 4'h6, 4'h6, RST_VAL);
      chk_outputs("rst_prio", RST_VAL, 1'b0);
      rst = 1'b0;
      in_valid = 1'b0;
      step();

      // Mid-stream reset drops the in-flight op, then one-cycle latency resumes
      issue(OP_ADD, 4'h2, 4'h3, '{y: 4'h5, c: 0, z: 0, n: 0, o: 0});
      rst = 1'b1;
      issue(OP_ADD, 4'h1, 4'h1, RST_VAL);
      chk_outputs("rst_mid", RST_VAL, 1'b0);
      rst = 1'b0;
      issue(OP_ADD, 4'h4, 4'h4, '{y: 4'h8, c: 0, z: 0, n: 1, o: 1});
      chk_outputs("post_rst", '{y: 4'h8, c: 0, z: 0, n: 1, o: 1}, 1'b1);
      in_valid = 1'b0;
      step();
      step();

      chk("sb.drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result bit width; SHALL support WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: op1  input  WIDTH  first operand, unsigned or two's complement.
REQ-005 Port: op2  input  WIDTH  second operand.
REQ-006 Port: opcode  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 Port: in_valid  input  1  operands and opcode valid this cycle.
REQ-008 Port: y  output  WIDTH  registered result.
REQ-009 Port: out_valid  output  1  y and flags valid.
REQ-010 Port: carry  output  1  ADD: carry-out; SUB: borrow (op1 < op2 unsigned); logic ops: 0.
REQ-011 Port: zero  output  1  y == 0.
REQ-012 Port: negative  output  1  MSB of y.
REQ-013 Port: overflow  output  1  signed overflow for ADD/SUB; logic ops: 0.

Function
REQ-014 ADD: y SHALL be (op1 + op2) mod 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-015 SUB: y SHALL be (op1 - op2) mod 2^WIDTH; carry = 1 iff op1 < op2 unsigned.
REQ-016 AND/OR: y SHALL be the bitwise op1 & op2 / op1 | op2.
REQ-017 ADD overflow SHALL be 1 iff op1 and op2 MSBs match and the y MSB differs.
REQ-018 SUB overflow SHALL be 1 iff the op1 and op2 MSBs differ and the y MSB differs from the op1 MSB.
REQ-019 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on y/flags after edge N with out_valid=1.
REQ-020 out_valid SHALL be in_valid delayed by one cycle.
REQ-021 When in_valid=0, y and flags SHALL hold their previous values.
REQ-022 Back-to-back in_valid SHALL give one result per cycle, with no bubbles and no stall.
REQ-023 zero and negative SHALL be derived from the result being registered, not recomputed from stale y.
REQ-024 No X SHALL propagate on outputs after reset, whatever the input values are.

Reset
REQ-025 rst=1 at a rising edge SHALL force y=0, out_valid=0, carry=0, zero=1, negative=0, overflow=0.
REQ-026 Reset SHALL take priority over in_valid in the same cycle; the operation presented in that cycle is discarded.
REQ-027 Reset asserted mid-stream SHALL drop the pending result; the first post-reset result SHALL appear 1 cycle after the first sampled in_valid.

Structure
REQ-028 A shared package alu_pkg SHALL hold the opcode enum (OP_ADD=00, OP_SUB=01, OP_AND=10, OP_OR=11) and the default WIDTH constant.
REQ-029 Combinational datapath SHALL be one sub-module, alu_core (op1, op2, opcode -> result, carry, overflow).
REQ-030 alu SHALL contain only the output registers, the valid pipeline and the zero/negative derivation.

Verification
REQ-031 Reset: rst=1 for 2 cycles -> y=0, zero=1, out_valid=0; then op1=5, op2=8, ADD -> next cycle y=D, carry=0, overflow=0, negative=1.
REQ-032 Sequential ops, one per cycle, op1=A, op2=8: SUB -> y=2, carry=0; AND -> y=8; OR -> y=A; carry=0 and overflow=0 on both logic ops.
REQ-033 Wrap: op1=F, op2=1, ADD -> y=0, carry=1, zero=1; op1=7, op2=1, ADD -> y=8, overflow=1, negative=1.
REQ-034 Borrow: op1=3, op2=5, SUB -> y=E, carry=1, negative=1, overflow=0; op1=8, op2=1, SUB -> y=7, overflow=1.
REQ-035 Hold/valid: in_valid=0 with changing operands -> y held, out_valid=0; rst asserted while in_valid=1 -> no result emitted, outputs at reset values.
